// File: rtl/program_load_controller_pkg.sv
// Shared widths and state encoding for the program-load controller,
// the CPU and the unified memory.
package program_load_controller_pkg;

    localparam int PLC_DATA_WIDTH = 16;
    localparam int PLC_ADDR_WIDTH = 5;
    localparam int PLC_DEPTH      = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        LOADED  = 2'd2,
        RUNNING = 2'd3
    } plc_state_e;

endpackage

// File: rtl/program_load_controller_load_write_stage.sv
// Registered host write path: memory write registers, saturating word
// count and running XOR checksum of accepted load words.
module load_write_stage
    import program_load_controller_pkg::*;
#(
    parameter int DATA_WIDTH = PLC_DATA_WIDTH,
    parameter int ADDR_WIDTH = PLC_ADDR_WIDTH,
    parameter int DEPTH      = PLC_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  accept_i,
    input  logic                  restart_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic [DATA_WIDTH-1:0] checksum_o
);

    localparam int CW = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  we_q, we_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] chk_q, chk_d;

    always_comb begin
        we_d   = accept_i;
        addr_d = addr_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        chk_d  = chk_q;
        if (accept_i) begin
            addr_d = addr_i;
            data_d = data_i;
        end
        // A reload restarts the statistics from the write that caused it
        if (restart_i) begin
            cnt_d = accept_i ? CW'(1) : '0;
            chk_d = accept_i ? data_i : '0;
        end else if (accept_i) begin
            if (cnt_q != CW'(DEPTH))
                cnt_d = cnt_q + CW'(1);
            chk_d = chk_q ^ data_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
            cnt_q  <= '0;
            chk_q  <= '0;
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
            we_q   <= we_d;
            cnt_q  <= cnt_d;
            chk_q  <= chk_d;
        end
    end

    assign addr_o     = addr_q;
    assign data_o     = data_q;
    assign we_o       = we_q;
    assign count_o    = cnt_q;
    assign checksum_o = chk_q;

endmodule

// File: rtl/program_load_controller.sv
// Program-load responder: host load FSM, then hands the memory port
// to the CPU through a register-selected mux.
module program_load_controller
    import program_load_controller_pkg::*;
#(
    parameter int DATA_WIDTH = PLC_DATA_WIDTH,
    parameter int ADDR_WIDTH = PLC_ADDR_WIDTH,
    parameter int DEPTH      = PLC_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] prog_data_in,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic                  prog_write_enable,
    input  logic                  start_execution,
    input  logic [ADDR_WIDTH-1:0] cpu_mem_addr,
    input  logic [DATA_WIDTH-1:0] cpu_mem_data,
    input  logic                  cpu_mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  mem_we,
    output logic                  load_done,
    output logic                  cpu_run,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic [DATA_WIDTH-1:0] load_checksum,
    output logic                  load_error
);

    plc_state_e state_q, state_d;
    logic       run_q, run_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       in_range, accept, restart;

    logic [ADDR_WIDTH-1:0] st_addr;
    logic [DATA_WIDTH-1:0] st_data;
    logic                  st_we;

    assign in_range = 32'(prog_addr) < DEPTH;
    assign accept   = prog_write_enable && in_range && (state_q != RUNNING);
    assign restart  = prog_write_enable && (state_q == LOADED);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE:    if (prog_write_enable) state_d = LOADING;
            LOADING: if (!prog_write_enable) state_d = LOADED;
            LOADED: begin
                if (prog_write_enable)    state_d = LOADING;
                else if (start_execution) state_d = RUNNING;
            end
            RUNNING: state_d = RUNNING;
            default: state_d = IDLE;
        endcase
        if (prog_write_enable && (!in_range || state_q == RUNNING))
            err_d = 1'b1;
        run_d  = (state_d == RUNNING);
        done_d = (state_d == LOADED);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    load_write_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_stage (
        .clock      (clock),
        .reset      (reset),
        .accept_i   (accept),
        .restart_i  (restart),
        .addr_i     (prog_addr),
        .data_i     (prog_data_in),
        .addr_o     (st_addr),
        .data_o     (st_data),
        .we_o       (st_we),
        .count_o    (word_count),
        .checksum_o (load_checksum)
    );

    // Select comes straight from a flop so the handover cannot glitch
    assign mem_addr     = run_q ? cpu_mem_addr : st_addr;
    assign mem_data_out = run_q ? cpu_mem_data : st_data;
    assign mem_we       = run_q ? cpu_mem_we   : st_we;
    assign load_done    = done_q;
    assign cpu_run      = run_q;
    assign load_error   = err_q;

endmodule

// File: tb/tb_program_load_controller.sv
// Directed bench: vector table for the main load/run flow plus
// hand-written sequences for reject, reload, reset and saturation.
module tb_program_load_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] prog_data_in = '0;
    logic [4:0]  prog_addr = '0;
    logic        prog_write_enable = 1'b0;
    logic        start_execution = 1'b0;
    logic [4:0]  cpu_mem_addr = '0;
    logic [15:0] cpu_mem_data = '0;
    logic        cpu_mem_we = 1'b0;

    logic [4:0]  a_addr, b_addr;
    logic [15:0] a_data, b_data;
    logic        a_we, b_we, a_done, b_done, a_run, b_run, a_err, b_err;
    logic [5:0]  a_cnt, b_cnt;
    logic [15:0] a_chk, b_chk;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    program_load_controller #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .DEPTH(32)) dut_a (
        .clock(clock), .reset(reset),
        .prog_data_in(prog_data_in), .prog_addr(prog_addr),
        .prog_write_enable(prog_write_enable), .start_execution(start_execution),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_data(cpu_mem_data), .cpu_mem_we(cpu_mem_we),
        .mem_addr(a_addr), .mem_data_out(a_data), .mem_we(a_we),
        .load_done(a_done), .cpu_run(a_run), .word_count(a_cnt),
        .load_checksum(a_chk), .load_error(a_err)
    );

    program_load_controller #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .DEPTH(16)) dut_b (
        .clock(clock), .reset(reset),
        .prog_data_in(prog_data_in), .prog_addr(prog_addr),
        .prog_write_enable(prog_write_enable), .start_execution(start_execution),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_data(cpu_mem_data), .cpu_mem_we(cpu_mem_we),
        .mem_addr(b_addr), .mem_data_out(b_data), .mem_we(b_we),
        .load_done(b_done), .cpu_run(b_run), .word_count(b_cnt),
        .load_checksum(b_chk), .load_error(b_err)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [15:0] data;
        logic        start;
        logic        cwe;
        logic [4:0]  caddr;
        logic [15:0] cdata;
        logic        x_we;
        logic [4:0]  x_addr;
        logic [15:0] x_data;
        logic        x_done;
        logic        x_run;
        logic [5:0]  x_cnt;
        logic [15:0] x_chk;
        logic        x_err;
    } vec_t;

    vec_t vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] a, input logic [15:0] d, input logic st);
        prog_write_enable = we;
        prog_addr         = a;
        prog_data_in      = d;
        start_execution   = st;
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, " addr"}, 32'(a_addr), 0);
        check({tag, " data"}, 32'(a_data), 0);
        check({tag, " we"},   32'(a_we), 0);
        check({tag, " done"}, 32'(a_done), 0);
        check({tag, " run"},  32'(a_run), 0);
        check({tag, " cnt"},  32'(a_cnt), 0);
        check({tag, " chk"},  32'(a_chk), 0);
        check({tag, " err"},  32'(a_err), 0);
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 16'h0, 1'b0);
        cpu_mem_we = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(vt[i].we, vt[i].addr, vt[i].data, vt[i].start);
            cpu_mem_we   = vt[i].cwe;
            cpu_mem_addr = vt[i].caddr;
            cpu_mem_data = vt[i].cdata;
            tick();
            check($sformatf("v%0d mem_we", i),   32'(a_we),   32'(vt[i].x_we));
            check($sformatf("v%0d mem_addr", i), 32'(a_addr), 32'(vt[i].x_addr));
            check($sformatf("v%0d mem_data", i), 32'(a_data), 32'(vt[i].x_data));
            check($sformatf("v%0d done", i),     32'(a_done), 32'(vt[i].x_done));
            check($sformatf("v%0d run", i),      32'(a_run),  32'(vt[i].x_run));
            check($sformatf("v%0d cnt", i),      32'(a_cnt),  32'(vt[i].x_cnt));
            check($sformatf("v%0d chk", i),      32'(a_chk),  32'(vt[i].x_chk));
            check($sformatf("v%0d err", i),      32'(a_err),  32'(vt[i].x_err));
        end
    endtask

    initial begin
        // we addr data start | cwe caddr cdata | exp we addr data done run cnt chk err
        vt[0] = '{1, 0, 16'h1234, 0, 1, 31, 16'hFFFF, 1, 0, 16'h1234, 0, 0, 1, 16'h1234, 0};
        vt[1] = '{1, 1, 16'hABCD, 0, 1, 31, 16'hFFFF, 1, 1, 16'hABCD, 0, 0, 2, 16'hB9F9, 0};
        vt[2] = '{1, 2, 16'h0F0F, 0, 1, 31, 16'hFFFF, 1, 2, 16'h0F0F, 0, 0, 3, 16'hB6F6, 0};
        vt[3] = '{0, 0, 16'h0000, 0, 1, 31, 16'hFFFF, 0, 2, 16'h0F0F, 1, 0, 3, 16'hB6F6, 0};
        vt[4] = '{0, 0, 16'h0000, 1, 1, 2,  16'h5555, 1, 2, 16'h5555, 0, 1, 3, 16'hB6F6, 0};
        vt[5] = '{1, 3, 16'h7777, 0, 0, 4,  16'h1111, 0, 4, 16'h1111, 0, 1, 3, 16'hB6F6, 1};
        vt[6] = '{0, 0, 16'h0000, 0, 1, 5,  16'h2222, 1, 5, 16'h2222, 0, 1, 3, 16'hB6F6, 1};

        #1;
        check_a_zero("reset");
        check("reset b err", 32'(b_err), 0);
        tick();
        reset = 1'b0;

        // Start without any load is ignored
        drive(1'b0, 5'd0, 16'h0, 1'b1);
        tick();
        tick();
        check("noload done", 32'(a_done), 0);
        check("noload run",  32'(a_run), 0);

        // Main flow
        apply(0, 6);
        cpu_mem_addr = 5'd7;
        cpu_mem_data = 16'h8888;
        cpu_mem_we   = 1'b0;
        #1;
        check("comb addr", 32'(a_addr), 7);
        check("comb data", 32'(a_data), 32'h8888);
        check("comb we",   32'(a_we), 0);

        // Out-of-range write on the DEPTH=16 instance
        do_reset();
        drive(1'b1, 5'd0, 16'h0001, 1'b0);
        tick();
        drive(1'b1, 5'd20, 16'hFFFF, 1'b0);
        tick();
        check("oor b we",   32'(b_we), 0);
        check("oor b cnt",  32'(b_cnt), 1);
        check("oor b err",  32'(b_err), 1);
        check("oor b addr", 32'(b_addr), 0);
        check("oor a we",   32'(a_we), 1);
        check("oor a addr", 32'(a_addr), 20);
        drive(1'b1, 5'd1, 16'h0002, 1'b0);
        tick();
        check("oor b we2",  32'(b_we), 1);
        check("oor b cnt2", 32'(b_cnt), 2);
        drive(1'b0, 5'd0, 16'h0, 1'b0);
        tick();
        check("oor b done", 32'(b_done), 1);
        check("oor b chk",  32'(b_chk), 32'h0003);
        check("oor b err3", 32'(b_err), 1);
        check("oor a cnt",  32'(a_cnt), 3);
        check("oor a err",  32'(a_err), 0);

        // Reload in LOADED with a simultaneous start: the write wins
        drive(1'b1, 5'd0, 16'h0001, 1'b1);
        tick();
        check("reload done", 32'(a_done), 0);
        check("reload run",  32'(a_run), 0);
        check("reload cnt",  32'(a_cnt), 1);
        check("reload chk",  32'(a_chk), 32'h0001);
        check("reload we",   32'(a_we), 1);
        drive(1'b0, 5'd0, 16'h0, 1'b0);
        tick();
        check("reload done2", 32'(a_done), 1);

        // Asynchronous reset mid-load
        do_reset();
        drive(1'b1, 5'd4, 16'h4444, 1'b0);
        tick();
        drive(1'b1, 5'd5, 16'h5555, 1'b0);
        tick();
        check("mid cnt", 32'(a_cnt), 2);
        reset = 1'b1;
        #1;
        check_a_zero("async");
        tick();
        reset = 1'b0;
        apply(0, 3);

        // Saturation of the word count
        do_reset();
        for (int i = 0; i < 33; i++) begin
            drive(1'b1, 5'(i % 32), 16'(i), 1'b0);
            tick();
            if (i == 30) check("sat cnt31", 32'(a_cnt), 31);
            if (i == 31) check("sat cnt32", 32'(a_cnt), 32);
        end
        check("sat cnt33", 32'(a_cnt), 32);
        check("sat chk",   32'(a_chk), 32'h0020);
        check("sat we",    32'(a_we), 1);
        check("sat addr",  32'(a_addr), 0);
        check("sat err",   32'(a_err), 0);
        drive(1'b0, 5'd0, 16'h0, 1'b0);
        tick();
        check("sat done", 32'(a_done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_load_controller.md
Name: program_load_controller

Overview:
- Responder side of the program-load interface driven into unified_system.
- Accepts host word writes (prog_addr/prog_data_in/prog_write_enable) and commits them into the shared instruction/data memory through a registered write port.
- Reports load completion via load_done and holds the CPU until start_execution.
- Once running, hands the memory port to the CPU through a registered-select mux.

Parameters:
- DATA_WIDTH, 16, width of instruction word and memory data
- ADDR_WIDTH, 5, width of program/memory address
- DEPTH, 32, number of valid memory words; addresses >= DEPTH are rejected

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- prog_data_in  input  DATA_WIDTH  host program word
- prog_addr  input  ADDR_WIDTH  host word address
- prog_write_enable  input  1  host write strobe, sampled every rising edge
- start_execution  input  1  level request to begin CPU execution
- cpu_mem_addr  input  ADDR_WIDTH  CPU memory address
- cpu_mem_data  input  DATA_WIDTH  CPU write data
- cpu_mem_we  input  1  CPU write enable
- mem_addr  output  ADDR_WIDTH  address to memory
- mem_data_out  output  DATA_WIDTH  write data to memory
- mem_we  output  1  memory write enable
- load_done  output  1  program load complete, CPU not yet started
- cpu_run  output  1  CPU enable; CPU holds PC and state while low
- word_count  output  ADDR_WIDTH+1  number of accepted load writes, saturating
- load_checksum  output  DATA_WIDTH  XOR of all accepted load words
- load_error  output  1  sticky; set on a rejected write

Behaviour:
- Reset (async, active-high): state=IDLE. mem_addr=0, mem_data_out=0, mem_we=0, load_done=0, cpu_run=0, word_count=0, load_checksum=0, load_error=0.
- States: IDLE, LOADING, LOADED, RUNNING.
- Accepted write: prog_write_enable=1, state is not RUNNING, and prog_addr < DEPTH.
- On each accepted write:
  - Next cycle: mem_we=1, mem_addr=prog_addr, mem_data_out=prog_data_in. Latency is exactly 1 cycle.
  - word_count increments, saturating at DEPTH.
  - load_checksum ^= prog_data_in.
- Rewriting the same address still counts and still XORs; there is no dedup.
- IDLE -> LOADING on the first sampled prog_write_enable=1. That write is processed in the same edge.
- LOADING stays while prog_write_enable=1. When prog_write_enable=0 is sampled -> LOADED, and load_done=1 from that edge.
- A host that never writes never reaches LOADED; load_done stays 0.
- LOADED with prog_write_enable=1 -> LOADING (reload):
  - load_done=0 on that edge.
  - word_count and load_checksum restart from this write (the count becomes 1).
- LOADED with start_execution=1 (prog_write_enable=0) -> RUNNING: load_done=0, cpu_run=1 from that edge.
- If prog_write_enable=1 and start_execution=1 are both sampled in LOADED, the write wins: go to LOADING, the start is ignored.
- start_execution in IDLE or LOADING is ignored.
- RUNNING is terminal until reset:
  - Memory port follows the CPU combinationally: mem_addr=cpu_mem_addr, mem_data_out=cpu_mem_data, mem_we=cpu_mem_we.
  - The select is registered off the state; there is no glitch on the transition edge.
  - Any prog_write_enable=1 sets load_error. Memory is not written, and the count and checksum are frozen.
- Outside RUNNING, the CPU inputs are ignored entirely.
- prog_addr >= DEPTH: write is dropped and load_error set. It is not counted and does not affect state transitions beyond IDLE->LOADING.
- load_error clears only on reset.
- Reset mid-load: everything returns to reset values immediately. The partially written memory content is not cleared.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'd0, LOADING=2'd1, LOADED=2'd2, RUNNING=2'd3.
  - DATA_WIDTH/ADDR_WIDTH defaults, shared with the CPU and memory.
- One natural sub-module: load_write_stage. It holds the registered host write path (addr/data/we registers, word_count, checksum).
- The controller FSM and the CPU/host mux stay in program_load_controller.

Test Plan:
- Load 3 words (0:1234, 1:ABCD, 2:0F0F) then drop write_enable:
  - mem_we pulses with matching addr/data 1 cycle after each.
  - load_done=1 at the edge after write_enable falls.
  - word_count=3, load_checksum=B6F6.
- After that load, assert start_execution:
  - Next edge cpu_run=1, load_done=0.
  - cpu_mem_we=1, addr=2, data=5555 appears on mem_* the same cycle.
  - A prog_write_enable pulse then sets load_error=1 with mem_we following cpu_mem_we only.
- DEPTH=16, write addr 20 (data FFFF) within a load:
  - No mem_we for it, word_count unchanged, load_error=1.
  - load_done is still reached.
- In LOADED, write addr 0 = 0001 with start_execution=1 the same cycle:
  - State -> LOADING, load_done=0, cpu_run=0.
  - word_count=1, checksum=0001.
- Assert reset mid-load after 2 writes:
  - All outputs are 0 asynchronously, before the next clock edge.
  - A subsequent full load completes normally.
- 33 consecutive writes at DEPTH=32 (addresses wrap 0..31,0): word_count saturates at 32.
